axi4_slv_mem: RTL and testbench



---
 rtl/axi4_slv_mem.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_axi4_slv_mem.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_slv_mem.sv
// AXI4 slave front-end. Turns AXI4 read/write bursts into a one-beat-at-a-time
// memory request/response handshake. One AXI transaction and one memory
// request are in flight at any time.

package axi4_slv_mem_pkg;

  localparam int unsigned axi_abits    = 48;
  localparam int unsigned axi_userbits = 1;
  localparam int unsigned axi_idbits   = 4;

  typedef struct packed {
    logic                    aw_valid;
    logic [axi_abits-1:0]    aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic [axi_idbits-1:0]   aw_id;
    logic [axi_userbits-1:0] aw_user;
    logic                    w_valid;
    logic [63:0]             w_data;
    logic [7:0]              w_strb;
    logic                    w_last;
    logic                    b_ready;
    logic                    ar_valid;
    logic [axi_abits-1:0]    ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic [axi_idbits-1:0]   ar_id;
    logic [axi_userbits-1:0] ar_user;
    logic                    r_ready;
  } axi4_slave_in_type;

  typedef struct packed {
    logic                    aw_ready;
    logic                    w_ready;
    logic                    b_valid;
    logic [1:0]              b_resp;
    logic [axi_idbits-1:0]   b_id;
    logic [axi_userbits-1:0] b_user;
    logic                    ar_ready;
    logic                    r_valid;
    logic [1:0]              r_resp;
    logic [63:0]             r_data;
    logic                    r_last;
    logic [axi_idbits-1:0]   r_id;
    logic [axi_userbits-1:0] r_user;
  } axi4_slave_out_type;

endpackage

// state  | meaning
// IDLE   | no transaction; AR (preferred) or AW may be accepted
// R_REQ  | read request presented to memory
// R_WAIT | read request accepted, waiting for memory response
// R_DATA | R beat presented on the bus, waiting for r_ready
// W_DATA | waiting for the next W beat
// W_REQ  | write request presented to memory
// W_RESP | write request accepted, waiting for memory response
// B_RESP | B response presented, waiting for b_ready
module axi4_slv_mem
  import axi4_slv_mem_pkg::*;
#(
  parameter int unsigned abits    = axi_abits,
  parameter int unsigned userbits = axi_userbits
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  axi4_slave_in_type  i_xslvi,
  output axi4_slave_out_type o_xslvo,
  output logic               o_req_valid,
  input  logic               i_req_ready,
  output logic               o_req_write,
  output logic [abits-1:0]   o_req_addr,
  output logic [2:0]         o_req_size,
  output logic [63:0]        o_req_wdata,
  output logic [7:0]         o_req_wstrb,
  input  logic               i_resp_valid,
  input  logic [63:0]        i_resp_rdata,
  input  logic               i_resp_err
);

  typedef enum logic [2:0] {
    IDLE,
    R_REQ,
    R_WAIT,
    R_DATA,
    W_DATA,
    W_REQ,
    W_RESP,
    B_RESP
  } state_t;

  localparam logic [1:0] burst_fixed = 2'b00;
  localparam logic [1:0] burst_wrap  = 2'b10;
  localparam logic [1:0] resp_okay   = 2'b00;
  localparam logic [1:0] resp_slverr = 2'b10;

  state_t                  state;
  logic [abits-1:0]        addr_r;
  logic [7:0]              len_r;
  logic [2:0]              size_r;
  logic [1:0]              burst_r;
  logic [axi_idbits-1:0]   id_r;
  logic [userbits-1:0]     user_r;
  logic [7:0]              cnt_r;
  logic                    err_r;
  logic                    beat_err_r;
  logic [63:0]             rdata_r;
  logic [63:0]             wdata_r;
  logic [7:0]              wstrb_r;

  logic                    last_beat;
  logic [abits-1:0]        addr_nxt;

  // Beat address after the current one. INCR stays inside its 4 KB page;
  // WRAP keeps the upper bits and rolls the low bits inside the window.
  // The reserved burst code is handled like INCR.
  function automatic logic [abits-1:0] next_addr(
    input logic [abits-1:0] a,
    input logic [7:0]       len,
    input logic [2:0]       size,
    input logic [1:0]       burst
  );
    logic [abits-1:0] step;
    logic [abits-1:0] inc;
    logic [abits-1:0] mask;
    logic [16:0]      win;
    step = abits'(1) << size;
    inc  = a + step;
    win  = ({9'd0, len} + 17'd1) << size;
    mask = abits'(win - 17'd1);
    case (burst)
      burst_fixed: next_addr = a;
      burst_wrap:  next_addr = (a & ~mask) | (inc & mask);
      default:     next_addr = {a[abits-1:12], inc[11:0]};
    endcase
  endfunction

  assign last_beat = (cnt_r == 8'd0);
  assign addr_nxt  = next_addr(addr_r, len_r, size_r, burst_r);

  // Transaction FSM: accepts AR/AW, issues one memory request per beat,
  // and returns R beats or a single B response.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state      <= IDLE;
      addr_r     <= '0;
      len_r      <= '0;
      size_r     <= '0;
      burst_r    <= '0;
      id_r       <= '0;
      user_r     <= '0;
      cnt_r      <= '0;
      err_r      <= 1'b0;
      beat_err_r <= 1'b0;
      rdata_r    <= '0;
      wdata_r    <= '0;
      wstrb_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_xslvi.ar_valid) begin
            addr_r     <= i_xslvi.ar_addr;
            len_r      <= i_xslvi.ar_len;
            size_r     <= i_xslvi.ar_size;
            burst_r    <= i_xslvi.ar_burst;
            id_r       <= i_xslvi.ar_id;
            user_r     <= i_xslvi.ar_user;
            cnt_r      <= i_xslvi.ar_len;
            err_r      <= 1'b0;
            beat_err_r <= 1'b0;
            state      <= R_REQ;
          end else if (i_xslvi.aw_valid) begin
            addr_r     <= i_xslvi.aw_addr;
            len_r      <= i_xslvi.aw_len;
            size_r     <= i_xslvi.aw_size;
            burst_r    <= i_xslvi.aw_burst;
            id_r       <= i_xslvi.aw_id;
            user_r     <= i_xslvi.aw_user;
            cnt_r      <= i_xslvi.aw_len;
            err_r      <= 1'b0;
            beat_err_r <= 1'b0;
            state      <= W_DATA;
          end
        end
        R_REQ: begin
          if (i_req_ready) begin
            state <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (i_resp_valid) begin
            rdata_r    <= i_resp_rdata;
            beat_err_r <= i_resp_err;
            state      <= R_DATA;
          end
        end
        R_DATA: begin
          if (i_xslvi.r_ready) begin
            if (last_beat) begin
              state <= IDLE;
            end else begin
              addr_r <= addr_nxt;
              cnt_r  <= cnt_r - 8'd1;
              state  <= R_REQ;
            end
          end
        end
        W_DATA: begin
          if (i_xslvi.w_valid) begin
            wdata_r <= i_xslvi.w_data;
            wstrb_r <= i_xslvi.w_strb;
            // Beat counting follows cnt; a misplaced w_last only flags the error.
            if (i_xslvi.w_last != last_beat) begin
              err_r <= 1'b1;
            end
            state <= W_REQ;
          end
        end
        W_REQ: begin
          if (i_req_ready) begin
            state <= W_RESP;
          end
        end
        W_RESP: begin
          if (i_resp_valid) begin
            err_r <= err_r | i_resp_err;
            if (last_beat) begin
              state <= B_RESP;
            end else begin
              addr_r <= addr_nxt;
              cnt_r  <= cnt_r - 8'd1;
              state  <= W_DATA;
            end
          end
        end
        B_RESP: begin
          if (i_xslvi.b_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory request fields come straight from the beat registers, so they
  // hold while a request is stalled.
  always_comb begin
    o_req_valid = (state == R_REQ) || (state == W_REQ);
    o_req_write = (state == W_REQ);
    o_req_addr  = addr_r;
    o_req_size  = size_r;
    o_req_wdata = wdata_r;
    o_req_wstrb = wstrb_r;
  end

  // AXI outputs decoded from the state register; reads win over writes.
  always_comb begin
    o_xslvo          = '0;
    o_xslvo.ar_ready = (state == IDLE);
    o_xslvo.aw_ready = (state == IDLE) && !i_xslvi.ar_valid;
    o_xslvo.w_ready  = (state == W_DATA);
    if (state == R_DATA) begin
      o_xslvo.r_valid = 1'b1;
      o_xslvo.r_data  = rdata_r;
      o_xslvo.r_id    = id_r;
      o_xslvo.r_user  = user_r;
      o_xslvo.r_last  = last_beat;
      o_xslvo.r_resp  = beat_err_r ? resp_slverr : resp_okay;
    end
    if (state == B_RESP) begin
      o_xslvo.b_valid = 1'b1;
      o_xslvo.b_id    = id_r;
      o_xslvo.b_user  = user_r;
      o_xslvo.b_resp  = err_r ? resp_slverr : resp_okay;
    end
  end

endmodule

// File: tb/tb_axi4_slv_mem.sv
// Testbench for axi4_slv_mem: directed scenarios followed by random bursts,
// checked against a byte-addressed memory model and burst address arithmetic.

module tb_axi4_slv_mem;
  import axi4_slv_mem_pkg::*;

  logic               clk = 1'b0;
  logic               nrst;
  axi4_slave_in_type  xi;
  axi4_slave_out_type xo;
  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [47:0]        req_addr;
  logic [2:0]         req_size;
  logic [63:0]        req_wdata;
  logic [7:0]         req_wstrb;
  logic               resp_valid;
  logic [63:0]        resp_rdata;
  logic               resp_err;

  typedef struct {
    logic        write;
    logic [47:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } req_rec_t;

  req_rec_t    req_log[$];
  logic [63:0] mem [logic [47:0]];
  logic [7:0]  wstrb_plan [256];
  int          resp_delay = 0;
  int          stall_max  = 0;
  int          err_req    = -1;
  int          n_assert   = 0;
  int          n_fail     = 0;

  axi4_slv_mem dut (
    .i_clk        (clk),
    .i_nrst       (nrst),
    .i_xslvi      (xi),
    .o_xslvo      (xo),
    .o_req_valid  (req_valid),
    .i_req_ready  (req_ready),
    .o_req_write  (req_write),
    .o_req_addr   (req_addr),
    .o_req_size   (req_size),
    .o_req_wdata  (req_wdata),
    .o_req_wstrb  (req_wstrb),
    .i_resp_valid (resp_valid),
    .i_resp_rdata (resp_rdata),
    .i_resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected address of beat k, straight from the burst rules.
  function automatic logic [47:0] exp_addr(input logic [47:0] start, input int len,
                                           input int size, input int burst, input int k);
    longint unsigned s, step, win, base, kk;
    s    = {16'd0, start};
    step = 64'd1 << size;
    kk   = longint'(k);
    case (burst)
      0: return start;
      2: begin
        win  = longint'(len + 1) * step;
        base = s - (s % win);
        return 48'(base + ((s - base + kk * step) % win));
      end
      default: begin
        base = s - (s % 4096);
        return 48'(base + (((s % 4096) + kk * step) % 4096));
      end
    endcase
  endfunction

  // Memory model: random accept stall, configurable response delay, error injection.
  initial begin : responder
    req_rec_t    r;
    int          idx;
    int          st;
    logic [63:0] cur;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (nrst && req_valid) begin
        r.write = req_write;
        r.addr  = req_addr;
        r.size  = req_size;
        r.wdata = req_wdata;
        r.wstrb = req_wstrb;
        st = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
        for (int i = 0; i < st; i++) begin
          @(negedge clk);
          check("req_hold_valid", req_valid, 1'b1);
          check("req_hold_addr", req_addr, r.addr);
          check("req_hold_ctl", {req_write, req_size, req_wstrb}, {r.write, r.size, r.wstrb});
          check("req_hold_wdata", req_wdata, r.wdata);
        end
        idx = req_log.size();
        req_log.push_back(r);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        for (int i = 0; i < resp_delay; i++) @(negedge clk);
        if (r.write) begin
          cur = mem.exists(r.addr) ? mem[r.addr] : 64'd0;
          for (int b = 0; b < 8; b++) if (r.wstrb[b]) cur[8*b +: 8] = r.wdata[8*b +: 8];
          mem[r.addr] = cur;
          resp_rdata  = '0;
        end else begin
          if (!mem.exists(r.addr)) mem[r.addr] = {$urandom, $urandom};
          resp_rdata = mem[r.addr];
        end
        resp_err   = (idx == err_req);
        resp_valid = 1'b1;
        @(negedge clk);
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the last R handshake.
  task automatic do_read(input logic [47:0] addr, input int len, input int size, input int burst,
                         input logic [3:0] id, input logic user, input int err_beat,
                         input bit stall_r, input bit aw_pending);
    int          base, t, n;
    logic [47:0] ea;
    logic [63:0] exp_data;
    logic [63:0] snap_d;
    logic [8:0]  snap_c;
    base    = req_log.size();
    err_req = (err_beat >= 0) ? base + err_beat : -1;
    xi.ar_addr  = addr;
    xi.ar_len   = 8'(len);
    xi.ar_size  = 3'(size);
    xi.ar_burst = 2'(burst);
    xi.ar_id    = id;
    xi.ar_user  = user;
    xi.ar_valid = 1'b1;
    if (aw_pending) begin
      #1;
      check("aw_ready_ar_priority", xo.aw_ready, 1'b0);
    end
    t = 0;
    while (!xo.ar_ready && t < 100) begin @(negedge clk); t++; end
    check("ar_ready", xo.ar_ready, 1'b1);
    @(negedge clk);
    xi.ar_valid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      t = 0;
      while (!xo.r_valid && t < 200) begin @(negedge clk); t++; end
      check("r_valid", xo.r_valid, 1'b1);
      if (aw_pending) check("aw_ready_busy", xo.aw_ready, 1'b0);
      if (stall_r) begin
        snap_d = xo.r_data;
        snap_c = {xo.r_valid, xo.r_resp, xo.r_last, xo.r_id, xo.r_user};
        @(negedge clk);
        check("r_hold_data", xo.r_data, snap_d);
        check("r_hold_ctl", {xo.r_valid, xo.r_resp, xo.r_last, xo.r_id, xo.r_user}, snap_c);
      end
      ea       = exp_addr(addr, len, size, burst, k);
      exp_data = mem.exists(ea) ? mem[ea] : 64'hdead_beef_dead_beef;
      check("r_data", xo.r_data, exp_data);
      check("r_last", xo.r_last, (k == len));
      check("r_resp", xo.r_resp, (k == err_beat) ? 2'b10 : 2'b00);
      check("r_id", xo.r_id, id);
      check("r_user", xo.r_user, user);
      xi.r_ready = 1'b1;
      @(negedge clk);
      xi.r_ready = 1'b0;
    end
    err_req = -1;
    check("rreq_count", req_log.size() - base, len + 1);
    n = (req_log.size() - base < len + 1) ? req_log.size() - base : len + 1;
    for (int k = 0; k < n; k++) begin
      check("rreq_addr", req_log[base+k].addr, exp_addr(addr, len, size, burst, k));
      check("rreq_ctl", {req_log[base+k].write, req_log[base+k].size}, {1'b0, 3'(size)});
    end
  endtask

  task automatic aw_phase(input logic [47:0] addr, input int len, input int size, input int burst,
                          input logic [3:0] id, input logic user);
    int t;
    xi.aw_addr  = addr;
    xi.aw_len   = 8'(len);
    xi.aw_size  = 3'(size);
    xi.aw_burst = 2'(burst);
    xi.aw_id    = id;
    xi.aw_user  = user;
    xi.aw_valid = 1'b1;
    t = 0;
    while (!xo.aw_ready && t < 100) begin @(negedge clk); t++; end
    check("aw_ready", xo.aw_ready, 1'b1);
    @(negedge clk);
    xi.aw_valid = 1'b0;
  endtask

  task automatic w_b_phase(input logic [47:0] addr, input int len, input int size, input int burst,
                           input logic [3:0] id, input logic user, input int bad_last,
                           input int err_beat);
    int          base, t, n;
    logic [63:0] wd [256];
    base    = req_log.size();
    err_req = (err_beat >= 0) ? base + err_beat : -1;
    for (int k = 0; k <= len; k++) begin
      wd[k]      = {$urandom, $urandom};
      xi.w_data  = wd[k];
      xi.w_strb  = wstrb_plan[k];
      xi.w_last  = (k == len) ^ (k == bad_last);
      xi.w_valid = 1'b1;
      t = 0;
      while (!xo.w_ready && t < 200) begin @(negedge clk); t++; end
      check("w_ready", xo.w_ready, 1'b1);
      @(negedge clk);
      xi.w_valid = 1'b0;
    end
    t = 0;
    while (!xo.b_valid && t < 200) begin @(negedge clk); t++; end
    check("b_valid", xo.b_valid, 1'b1);
    check("b_resp", xo.b_resp, (bad_last >= 0 || err_beat >= 0) ? 2'b10 : 2'b00);
    check("b_id", xo.b_id, id);
    check("b_user", xo.b_user, user);
    xi.b_ready = 1'b1;
    @(negedge clk);
    xi.b_ready = 1'b0;
    check("b_done", xo.b_valid, 1'b0);
    err_req = -1;
    check("wreq_count", req_log.size() - base, len + 1);
    n = (req_log.size() - base < len + 1) ? req_log.size() - base : len + 1;
    for (int k = 0; k < n; k++) begin
      check("wreq_addr", req_log[base+k].addr, exp_addr(addr, len, size, burst, k));
      check("wreq_ctl", {req_log[base+k].write, req_log[base+k].size}, {1'b1, 3'(size)});
      check("wreq_data", req_log[base+k].wdata, wd[k]);
      check("wreq_strb", req_log[base+k].wstrb, wstrb_plan[k]);
    end
  endtask

  task automatic do_write(input logic [47:0] addr, input int len, input int size, input int burst,
                          input logic [3:0] id, input logic user, input int bad_last,
                          input int err_beat);
    aw_phase(addr, len, size, burst, id, user);
    w_b_phase(addr, len, size, burst, id, user, bad_last, err_beat);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [47:0] a;
    int          base, len, size, burst, errb, badl, t;
    xi   = '0;
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_r_valid", xo.r_valid, 1'b0);
    check("rst_b_valid", xo.b_valid, 1'b0);
    check("rst_w_ready", xo.w_ready, 1'b0);
    check("rst_ar_ready", xo.ar_ready, 1'b1);
    check("rst_aw_ready", xo.aw_ready, 1'b1);
    check("rst_fields", {xo.r_data, xo.r_resp, xo.b_resp}, '0);
    check("rst_req_addr", req_addr, '0);
    nrst = 1'b1;
    @(negedge clk);
    check("post_rst_ar_ready", xo.ar_ready, 1'b1);

    // Single read, zero-wait memory
    mem[48'h100] = 64'h1122334455667788;
    do_read(48'h100, 0, 3, 1, 4'd5, 1'b0, -1, 1'b0, 1'b0);
    check("single_ar_ready_again", xo.ar_ready, 1'b1);
    repeat (3) @(negedge clk);
    check("single_no_extra_r", xo.r_valid, 1'b0);

    // INCR read across the 4 KB page boundary with r_ready stalls
    base = req_log.size();
    do_read(48'h0FF8, 3, 3, 1, 4'd2, 1'b1, -1, 1'b1, 1'b0);
    check("incr_page_wrap_beat2", req_log[base+1].addr, 48'h0000);
    check("incr_page_wrap_beat4", req_log[base+3].addr, 48'h0010);

    // WRAP write with mixed strobes
    wstrb_plan[0] = 8'hFF; wstrb_plan[1] = 8'h0F; wstrb_plan[2] = 8'hF0; wstrb_plan[3] = 8'hFF;
    base = req_log.size();
    do_write(48'h1018, 3, 3, 2, 4'd9, 1'b0, -1, -1);
    check("wrap_beat2_addr", req_log[base+1].addr, 48'h1000);
    check("wrap_beat4_addr", req_log[base+3].addr, 48'h1010);

    // Simultaneous AR and AW: read wins, write follows
    xi.aw_addr  = 48'h2000;
    xi.aw_len   = 8'd1;
    xi.aw_size  = 3'd3;
    xi.aw_burst = 2'd1;
    xi.aw_id    = 4'd7;
    xi.aw_user  = 1'b1;
    xi.aw_valid = 1'b1;
    do_read(48'h3000, 1, 3, 1, 4'd6, 1'b1, -1, 1'b0, 1'b1);
    check("aw_ready_after_read", xo.aw_ready, 1'b1);
    @(negedge clk);
    xi.aw_valid = 1'b0;
    wstrb_plan[0] = 8'hFF; wstrb_plan[1] = 8'hFF;
    w_b_phase(48'h2000, 1, 3, 1, 4'd7, 1'b1, -1, -1);

    // Memory error on beat 2 of a read, then of a write
    do_read(48'h400, 3, 3, 1, 4'd1, 1'b0, 1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) wstrb_plan[k] = 8'hFF;
    do_write(48'h500, 3, 3, 1, 4'd3, 1'b0, -1, 1);

    // Early w_last on a two-beat write
    do_write(48'h600, 1, 3, 1, 4'd4, 1'b1, 0, -1);

    // Reset during R_WAIT of beat 2
    resp_delay = 8;
    base = req_log.size();
    xi.ar_addr  = 48'h200;
    xi.ar_len   = 8'd3;
    xi.ar_size  = 3'd3;
    xi.ar_burst = 2'd1;
    xi.ar_id    = 4'd3;
    xi.ar_user  = 1'b0;
    xi.ar_valid = 1'b1;
    @(negedge clk);
    xi.ar_valid = 1'b0;
    xi.r_ready  = 1'b1;
    t = 0;
    while (req_log.size() < base + 2 && t < 200) begin @(negedge clk); t++; end
    check("rst_reach_beat2", req_log.size() - base, 2);
    @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    check("midrst_req_valid", req_valid, 1'b0);
    check("midrst_r_valid", xo.r_valid, 1'b0);
    check("midrst_req_addr", req_addr, '0);
    check("midrst_ar_ready", xo.ar_ready, 1'b1);
    check("midrst_b_valid", xo.b_valid, 1'b0);
    xi.r_ready = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (12) @(negedge clk);
    check("postrst_no_r", xo.r_valid, 1'b0);
    check("postrst_ar_ready", xo.ar_ready, 1'b1);
    resp_delay = 0;
    do_read(48'h808, 0, 3, 1, 4'd8, 1'b1, -1, 1'b0, 1'b0);

    // Random bursts
    for (int it = 0; it < 24; it++) begin
      burst = int'($urandom_range(3, 0));
      size  = int'($urandom_range(3, 0));
      if (burst == 2) len = (1 << $urandom_range(3, 1)) - 1;
      else            len = int'($urandom_range(7, 0));
      a = {16'($urandom), 32'($urandom)};
      a = a & ~((48'd1 << size) - 48'd1);
      stall_max  = int'($urandom_range(2, 0));
      resp_delay = int'($urandom_range(2, 0));
      errb = ($urandom_range(3, 0) == 0) ? int'($urandom_range(len, 0)) : -1;
      if ($urandom_range(1, 0) == 1) begin
        do_read(a, len, size, burst, 4'($urandom), 1'($urandom), errb,
                1'($urandom_range(1, 0)), 1'b0);
      end else begin
        for (int k = 0; k <= len; k++) wstrb_plan[k] = 8'($urandom);
        badl = ($urandom_range(3, 0) == 0) ? int'($urandom_range(len, 0)) : -1;
        do_write(a, len, size, burst, 4'($urandom), 1'($urandom), badl, errb);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
